// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// -----------------------------------------------------------------------------
// Forwarding and hazard unit for the 5-stage pipeline. Supports NUM_SRC source
// operands and FWD_DEPTH forwarding stages after EX. The nearest stage has
// priority. Also generates load-use stalls for LOAD_LAT bubbles and a
// memory-busy freeze.
//
// Optional feature: define FWD_PERF_CNT_EN to build the two 32-bit saturating
// performance counters. Without it, both counter outputs are tied to 0.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-low reset
//   id_valid_i        ID stage holds a real instruction
//   id_rs_addr_i      ID source addresses, operand j at [j*REG_ADDR_W +: REG_ADDR_W]
//   ex_valid_i        EX stage holds a real instruction
//   ex_memread_i      EX instruction is a load
//   ex_rd_addr_i      EX destination register
//   ex_rs_addr_i      EX source addresses, same packing as id_rs_addr_i
//   stg_valid_i       per-stage valid (index 0 = MEM, 1 = WB, ...)
//   stg_regwrite_i    per-stage RegWrite
//   stg_rd_addr_i     per-stage destination register
//   mem_busy_i        data memory not ready; the whole pipeline holds
//   sel_o             per-operand select: 0 = register file, k = stage k-1
//   stall_o           hold PC and IF/ID
//   flush_o           insert a bubble into ID/EX
//   freeze_o          hold all pipeline registers
//   lu_stall_cnt_o    cycles with stall_o=1 (saturating)
//   fwd_cnt_o         unfrozen cycles with any operand forwarded (saturating)
//   state_o           debug: hazard FSM state (0 = RUN, 1 = BUBBLE)
//
// Handshake: this block has no valid/ready pairs. Every *_valid_i input is a
// level qualifier for its stage in the current cycle. All hazard outputs are
// combinational and apply to that same cycle.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = $clog2(LOAD_LAT + 1),
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            id_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_rs_addr_i,
  input  logic                            ex_valid_i,
  input  logic                            ex_memread_i,
  input  logic [REG_ADDR_W-1:0]           ex_rd_addr_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   ex_rs_addr_i,
  input  logic [FWD_DEPTH-1:0]            stg_valid_i,
  input  logic [FWD_DEPTH-1:0]            stg_regwrite_i,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] stg_rd_addr_i,
  input  logic                            mem_busy_i,
  output logic [NUM_SRC*SEL_W-1:0]        sel_o,
  output logic                            stall_o,
  output logic                            flush_o,
  output logic                            freeze_o,
  output logic [31:0]                     lu_stall_cnt_o,
  output logic [31:0]                     fwd_cnt_o,
  output logic                            state_o
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} hazState_t;

  hazState_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             idMatch;
  logic             luHit;
  logic             anyFwd;
  logic             stallInt;

  // Forwarding select. Stages are scanned from farthest to nearest, so a
  // nearer match overwrites a farther one. This gives nearest-stage priority.
  always_comb begin
    sel_o = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (ex_valid_i && stg_valid_i[k] && stg_regwrite_i[k] &&
            (stg_rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
            (stg_rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] ==
             ex_rs_addr_i[j*REG_ADDR_W +: REG_ADDR_W])) begin
          sel_o[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  assign anyFwd = |sel_o;

  // Load-use detect: the load in EX writes a register that ID reads.
  always_comb begin
    idMatch = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (id_rs_addr_i[j*REG_ADDR_W +: REG_ADDR_W] == ex_rd_addr_i) idMatch = 1'b1;
    end
  end

  assign luHit = ex_valid_i & ex_memread_i & (ex_rd_addr_i != '0) &
                 id_valid_i & idMatch;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // FSM next state. A busy cycle holds everything, which stretches a bubble
  // in progress. cnt counts the bubble cycles still owed after the first.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (!mem_busy_i) begin
      case (state)
        RUN: begin
          if (luHit && (LOAD_LAT > 1)) begin
            stateNext = BUBBLE;
            cntNext   = CNT_W'(LOAD_LAT - 1);
          end
        end
        BUBBLE: begin
          if (cnt == CNT_W'(1)) stateNext = RUN;
          cntNext = cnt - CNT_W'(1);
        end
        default: begin
          stateNext = RUN;
          cntNext   = '0;
        end
      endcase
    end
  end

  // FSM outputs. In BUBBLE, EX holds a bubble, so luHit is not consulted.
  always_comb begin
    stallInt = 1'b0;
    if (!mem_busy_i) begin
      case (state)
        RUN:     stallInt = luHit;
        BUBBLE:  stallInt = 1'b1;
        default: stallInt = 1'b0;
      endcase
    end
  end

  assign stall_o  = stallInt;
  assign flush_o  = stallInt;
  assign freeze_o = mem_busy_i;
  assign state_o  = (state == BUBBLE);

`ifdef FWD_PERF_CNT_EN
  logic [31:0] luStallCnt;
  logic [31:0] fwdCnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      luStallCnt <= '0;
      fwdCnt     <= '0;
    end else begin
      if (stallInt && (luStallCnt != 32'hFFFF_FFFF)) luStallCnt <= luStallCnt + 32'd1;
      if (anyFwd && !mem_busy_i && (fwdCnt != 32'hFFFF_FFFF)) fwdCnt <= fwdCnt + 32'd1;
    end
  end

  assign lu_stall_cnt_o = luStallCnt;
  assign fwd_cnt_o      = fwdCnt;
`else
  logic unusedFwd;
  assign unusedFwd      = anyFwd;
  assign lu_stall_cnt_o = '0;
  assign fwd_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
// Three instances share one stimulus set:
//   uA: FWD_DEPTH=2, LOAD_LAT=1 (defaults)
//   uB: FWD_DEPTH=3, LOAD_LAT=2
//   uC: FWD_DEPTH=4, LOAD_LAT=3
// A behavioural model (match search plus a remaining-stall count) is compared
// against every instance at each falling edge. Directed sequences also hold
// hand-computed literal expectations.
module tb_fwd_hazard_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic        idValid;
  logic [9:0]  idRs;
  logic        exValid;
  logic        exMemread;
  logic [4:0]  exRd;
  logic [9:0]  exRs;
  logic [3:0]  stgValid;
  logic [3:0]  stgRegwrite;
  logic [19:0] stgRd;
  logic        memBusy;

  // ---------------- DUT outputs ----------------
  logic [3:0]  selA, selB;
  logic [5:0]  selC;
  logic [2:0]  stallV, flushV, freezeV, stateV;
  logic [31:0] luCnt  [3];
  logic [31:0] fwdCnt [3];

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.FWD_DEPTH(2), .LOAD_LAT(1)) uA (
    .clk_i(clk), .rst_i(rstN), .id_valid_i(idValid), .id_rs_addr_i(idRs),
    .ex_valid_i(exValid), .ex_memread_i(exMemread), .ex_rd_addr_i(exRd),
    .ex_rs_addr_i(exRs), .stg_valid_i(stgValid[1:0]), .stg_regwrite_i(stgRegwrite[1:0]),
    .stg_rd_addr_i(stgRd[9:0]), .mem_busy_i(memBusy), .sel_o(selA),
    .stall_o(stallV[0]), .flush_o(flushV[0]), .freeze_o(freezeV[0]),
    .lu_stall_cnt_o(luCnt[0]), .fwd_cnt_o(fwdCnt[0]), .state_o(stateV[0]));

  fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) uB (
    .clk_i(clk), .rst_i(rstN), .id_valid_i(idValid), .id_rs_addr_i(idRs),
    .ex_valid_i(exValid), .ex_memread_i(exMemread), .ex_rd_addr_i(exRd),
    .ex_rs_addr_i(exRs), .stg_valid_i(stgValid[2:0]), .stg_regwrite_i(stgRegwrite[2:0]),
    .stg_rd_addr_i(stgRd[14:0]), .mem_busy_i(memBusy), .sel_o(selB),
    .stall_o(stallV[1]), .flush_o(flushV[1]), .freeze_o(freezeV[1]),
    .lu_stall_cnt_o(luCnt[1]), .fwd_cnt_o(fwdCnt[1]), .state_o(stateV[1]));

  fwd_hazard_unit #(.FWD_DEPTH(4), .LOAD_LAT(3)) uC (
    .clk_i(clk), .rst_i(rstN), .id_valid_i(idValid), .id_rs_addr_i(idRs),
    .ex_valid_i(exValid), .ex_memread_i(exMemread), .ex_rd_addr_i(exRd),
    .ex_rs_addr_i(exRs), .stg_valid_i(stgValid), .stg_regwrite_i(stgRegwrite),
    .stg_rd_addr_i(stgRd), .mem_busy_i(memBusy), .sel_o(selC),
    .stall_o(stallV[2]), .flush_o(flushV[2]), .freeze_o(freezeV[2]),
    .lu_stall_cnt_o(luCnt[2]), .fwd_cnt_o(fwdCnt[2]), .state_o(stateV[2]));

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          depth [3] = '{2, 3, 4};
  int          lat   [3] = '{1, 2, 3};
  int          rem   [3] = '{0, 0, 0};   // stall cycles still owed
  int          nRem  [3] = '{0, 0, 0};
  logic [31:0] mLu   [3] = '{0, 0, 0};
  logic [31:0] mFwd  [3] = '{0, 0, 0};
  logic [31:0] nLu   [3] = '{0, 0, 0};
  logic [31:0] nFwd  [3] = '{0, 0, 0};

  // First (nearest) stage that writes the operand's register, or 0.
  function automatic int modelSel(input int d, input int j);
    logic [4:0] rs;
    logic [4:0] rd;
    rs = exRs[j*5 +: 5];
    if (!exValid) return 0;
    for (int k = 0; k < d; k++) begin
      rd = stgRd[k*5 +: 5];
      if (stgValid[k] && stgRegwrite[k] && rd != 5'd0 && rd == rs) return k + 1;
    end
    return 0;
  endfunction

  function automatic logic modelLuHit();
    return exValid && exMemread && exRd != 5'd0 && idValid &&
           (exRd == idRs[4:0] || exRd == idRs[9:5]);
  endfunction

  function automatic int actSel(input int i, input int j);
    case (i)
      0:       return int'(selA[j*2 +: 2]);
      1:       return int'(selB[j*2 +: 2]);
      default: return int'(selC[j*3 +: 3]);
    endcase
  endfunction

  logic        eStall, anyF;
  int          es;
  logic [31:0] expLu, expFwd;

  // Compare process: every falling edge, every instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstN) begin
        rem[i]  = 0;
        mLu[i]  = '0;
        mFwd[i] = '0;
      end
      eStall = !memBusy && (rem[i] > 0 || modelLuHit());
      anyF = 1'b0;
      for (int j = 0; j < 2; j++) begin
        es = modelSel(depth[i], j);
        check($sformatf("sel_u%0d_op%0d", i, j), 32'(actSel(i, j)), 32'(es));
        if (es != 0) anyF = 1'b1;
      end
      check($sformatf("stall_u%0d", i), 32'(stallV[i]), 32'(eStall));
      check($sformatf("flush_u%0d", i), 32'(flushV[i]), 32'(eStall));
      check($sformatf("freeze_u%0d", i), 32'(freezeV[i]), 32'(memBusy));
      check($sformatf("state_u%0d", i), 32'(stateV[i]), 32'(rem[i] > 0));
`ifdef FWD_PERF_CNT_EN
      expLu  = mLu[i];
      expFwd = mFwd[i];
`else
      expLu  = '0;
      expFwd = '0;
`endif
      check($sformatf("lucnt_u%0d", i), luCnt[i], expLu);
      check($sformatf("fwdcnt_u%0d", i), fwdCnt[i], expFwd);

      if (memBusy)         nRem[i] = rem[i];
      else if (rem[i] > 0) nRem[i] = rem[i] - 1;
      else if (eStall)     nRem[i] = lat[i] - 1;
      else                 nRem[i] = 0;
      nLu[i]  = (eStall && mLu[i] != 32'hFFFF_FFFF) ? mLu[i] + 32'd1 : mLu[i];
      nFwd[i] = (anyF && !memBusy && mFwd[i] != 32'hFFFF_FFFF) ? mFwd[i] + 32'd1 : mFwd[i];
    end
  end

  always @(posedge clk) begin
    if (rstN) begin
      for (int i = 0; i < 3; i++) begin
        rem[i]  = nRem[i];
        mLu[i]  = nLu[i];
        mFwd[i] = nFwd[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clearIn();
    idValid = 1'b0; idRs = '0; exValid = 1'b0; exMemread = 1'b0; exRd = '0;
    exRs = '0; stgValid = '0; stgRegwrite = '0; stgRd = '0; memBusy = 1'b0;
  endtask

  task automatic waitSample();
    @(negedge clk); #1;
  endtask

  task automatic nextDrive();
    @(posedge clk); #1;
  endtask

  task automatic loadX5();
    clearIn();
    exValid = 1'b1; exMemread = 1'b1; exRd = 5'd5; idValid = 1'b1; idRs = {5'd0, 5'd5};
  endtask

  // ---------------- directed stimulus ----------------
  logic [1:0] expQ[$];
  logic [1:0] expPair;
  int         stallCnt [3];

  initial begin
    clearIn();
    rstN = 1'b0;
    waitSample();
    check("rst_stall_c", 32'(stallV[2]), 32'd0);
    check("rst_state_c", 32'(stateV[2]), 32'd0);
    check("rst_lucnt_a", luCnt[0], 32'd0);
    nextDrive();
    rstN = 1'b1;

    // Priority: stage0 and stage1 both write x3.
    exValid = 1'b1; exRs = {5'd3, 5'd3}; stgValid = 4'hF; stgRegwrite = 4'hF;
    stgRd = {5'd0, 5'd0, 5'd3, 5'd3};
    waitSample();
    check("prio_a", 32'(selA), 32'h5);
    check("prio_c", 32'(selC), 32'h09);
    nextDrive();
    stgRegwrite = 4'b1110;
    waitSample();
    check("prio_wb_a", 32'(selA), 32'hA);
    nextDrive();
    stgRd = '0;
    waitSample();
    check("rd0_a", 32'(selA), 32'h0);

    // Valid gating: stage0 x7, stage1 x3 invalid, stage2 x3 valid.
    nextDrive();
    stgRegwrite = 4'hF; stgValid = 4'b1101; stgRd = {5'd0, 5'd3, 5'd3, 5'd7};
    waitSample();
    check("vgate_a", 32'(selA), 32'h0);
    check("vgate_b", 32'(selB), 32'hF);
    check("vgate_c", 32'(selC), 32'h1B);

    // Mixed operands: op0=x3 -> stage1, op1=x7 -> stage0.
    nextDrive();
    stgValid = 4'hF; exRs = {5'd7, 5'd3};
    waitSample();
    check("mixed_a", 32'(selA), 32'h6);
    nextDrive();
    exValid = 1'b0;
    waitSample();
    check("exv0_c", 32'(selC), 32'h0);

    // A load to x0 never stalls.
    nextDrive();
    clearIn();
    exValid = 1'b1; exMemread = 1'b1; exRd = 5'd0; idValid = 1'b1; idRs = '0;
    waitSample();
    check("x0_lu_c", 32'(stallV[2]), 32'd0);

    // Load-use without busy: stall lengths are 1, 2 and 3.
    nextDrive();
    loadX5();
    stallCnt = '{0, 0, 0};
    for (int c = 0; c < 6; c++) begin
      waitSample();
      for (int i = 0; i < 3; i++) stallCnt[i] += int'(stallV[i]);
      nextDrive();
      exValid = 1'b0;
    end
    check("lulen_a", 32'(stallCnt[0]), 32'd1);
    check("lulen_b", 32'(stallCnt[1]), 32'd2);
    check("lulen_c", 32'(stallCnt[2]), 32'd3);
`ifdef FWD_PERF_CNT_EN
    check("lucnt_after_a", luCnt[0], 32'd1);
    check("lucnt_after_c", luCnt[2], 32'd3);
`endif

    // Load-use with mem_busy for 3 cycles in uB's 2nd stall cycle.
    loadX5();
    expQ = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};  // {stall, freeze} of uB
    for (int c = 0; c < 6; c++) begin
      waitSample();
      expPair = expQ.pop_front();
      check($sformatf("busy_b_c%0d", c), 32'({stallV[1], freezeV[1]}), 32'(expPair));
      nextDrive();
      exValid = 1'b0;
      memBusy = (c + 1 >= 1) && (c + 1 <= 3);
    end
    repeat (3) nextDrive();

    // Reset in uC's 2nd stall cycle aborts the bubble.
    loadX5();
    waitSample();
    check("rsthit_c", 32'(stallV[2]), 32'd1);
    nextDrive();
    exValid = 1'b0;
    rstN = 1'b0;
    waitSample();
    check("rstmid_stall_c", 32'(stallV[2]), 32'd0);
    check("rstmid_state_c", 32'(stateV[2]), 32'd0);
    check("rstmid_lucnt_c", luCnt[2], 32'd0);
    nextDrive();
    rstN = 1'b1;
    stallCnt = '{0, 0, 0};
    for (int c = 0; c < 3; c++) begin
      waitSample();
      stallCnt[2] += int'(stallV[2]);
      nextDrive();
    end
    check("rstpost_c", 32'(stallCnt[2]), 32'd0);

`ifdef FWD_PERF_CNT_EN
    // Saturation of uA's forward counter.
    clearIn();
    exValid = 1'b1; exRs = {5'd3, 5'd3}; stgValid = 4'h1; stgRegwrite = 4'h1;
    stgRd = {15'd0, 5'd3};
    force uA.fwdCnt = 32'hFFFF_FFFE;
    mFwd[0] = 32'hFFFF_FFFE;
    waitSample();
    release uA.fwdCnt;
    repeat (3) nextDrive();
    waitSample();
    check("sat_fwd_a", fwdCnt[0], 32'hFFFF_FFFF);
`endif

    nextDrive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage pipelined CPU. It generalises operand forwarding to NUM_SRC source operands and FWD_DEPTH forwarding stages, with nearest-stage priority. It adds load-use stall generation for a configurable load latency and a memory-busy freeze. It sits beside the ID/EX pipeline registers and drives the EX operand muxes, the PC/IF-ID write enables and the ID/EX bubble insertion.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction
- FWD_DEPTH, 2, forwarding stages after EX; index 0 = MEM, 1 = WB, …
- LOAD_LAT, 1, load-use bubbles required (1..FWD_DEPTH-1, min 1); CNT_W = clog2(LOAD_LAT+1)
- SEL_W, clog2(FWD_DEPTH+1), select width per operand

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_addr_i  in  NUM_SRC*REG_ADDR_W  ID source addresses, operand j at [j*REG_ADDR_W +: REG_ADDR_W]
- ex_valid_i  in  1  EX stage holds a real instruction
- ex_memread_i  in  1  EX instruction is a load
- ex_rd_addr_i  in  REG_ADDR_W  EX destination
- ex_rs_addr_i  in  NUM_SRC*REG_ADDR_W  EX source addresses
- stg_valid_i  in  FWD_DEPTH  per-stage valid
- stg_regwrite_i  in  FWD_DEPTH  per-stage RegWrite
- stg_rd_addr_i  in  FWD_DEPTH*REG_ADDR_W  per-stage destination
- mem_busy_i  in  1  data memory not ready; whole pipeline must hold
- sel_o  out  NUM_SRC*SEL_W  operand select: 0 = register file, k = stage k-1
- stall_o  out  1  hold PC and IF/ID
- flush_o  out  1  insert bubble into ID/EX
- freeze_o  out  1  hold all pipeline registers
- lu_stall_cnt_o  out  32  load-use stall cycles (see Configuration)
- fwd_cnt_o  out  32  cycles with at least one forwarded operand

## Operation
- Forwarding (combinational):
  - For each operand j, when ex_valid_i=1, sel_o[j] = k+1 for the smallest k with stg_valid_i[k] & stg_regwrite_i[k] & stg_rd_addr[k]!=0 & stg_rd_addr[k]==ex_rs[j].
  - sel_o[j] is 0 otherwise, or when ex_valid_i=0.
  - The nearest stage always wins.
- Load-use detect: lu_hit = ex_valid_i & ex_memread_i & ex_rd_addr_i!=0 & id_valid_i & (ex_rd_addr_i equals any id_rs[j]).
- FSM states RUN, BUBBLE; bubble counter cnt is CNT_W bits.
  - RUN: lu_hit & !mem_busy_i drives stall_o=flush_o=1. If LOAD_LAT>1, load cnt=LOAD_LAT-1 and go to BUBBLE; otherwise stay in RUN.
  - BUBBLE: stall_o=flush_o=1. On each non-busy cycle, decrement cnt; when cnt==1 before the decrement, go to RUN. lu_hit is ignored because EX holds a bubble.
- Freeze:
  - mem_busy_i=1 drives freeze_o=1 and forces stall_o=flush_o=0.
  - State, cnt and counters hold. sel_o is still computed.
- Counters, with FWD_PERF_CNT_EN defined:
  - lu_stall_cnt_o increments on each cycle with stall_o=1.
  - fwd_cnt_o increments on each cycle with any sel_o[j]!=0 and freeze_o=0.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- sel_o, stall_o, flush_o and freeze_o are combinational: zero-cycle latency from inputs and state.
- Load-use stall lasts exactly LOAD_LAT non-frozen cycles, starting in the cycle lu_hit is first seen.
- Reset (rst_i=0), asynchronously and immediately: state=RUN, cnt=0, both counters 0. stall_o and flush_o are 0 unless lu_hit. freeze_o follows mem_busy_i.
- Reset asserted mid-BUBBLE aborts the bubble immediately; no residual stall after release.
- mem_busy_i asserted in a BUBBLE cycle extends the bubble: the remaining count resumes after busy drops.
- Register 0 is never forwarded and never causes a load-use stall.

## Configuration
- FWD_PERF_CNT_EN defined: both 32-bit saturating counters are implemented.
- FWD_PERF_CNT_EN undefined: counter registers are removed; lu_stall_cnt_o and fwd_cnt_o are tied to 0. Forwarding and stall behaviour are identical in both builds.

## Test plan
- Priority: defaults; ex_rs=(3,3); stg0 writes x3, stg1 writes x3 -> sel=(1,1). Drop stg0 regwrite -> sel=(2,2). Set rd=0 in all stages -> sel=(0,0).
- Valid gating: stg1 matches with stg_valid_i[1]=0 -> sel=0. ex_valid_i=0 with matches present -> sel=0.
- Load-use, LOAD_LAT=1: load to x5 in EX, ID reads x5 -> stall_o=flush_o=1 for exactly 1 cycle. lu_stall_cnt_o=1 afterwards with FWD_PERF_CNT_EN.
- Load-use, LOAD_LAT=2, FWD_DEPTH=3: same stimulus -> stall for 2 cycles. mem_busy_i=1 for 3 cycles in the 2nd bubble cycle -> freeze_o=1 and stall_o=0 for those 3 cycles, then 1 more stall cycle.
- Reset mid-bubble (LOAD_LAT=3, rst_i low in 2nd bubble cycle, lu_hit=0) -> stall_o=0 at once, state RUN, counters 0.
- Saturation (FWD_PERF_CNT_EN): force counter to 32'hFFFF_FFFE, forward on 3 cycles -> fwd_cnt_o holds 32'hFFFF_FFFF.
